enc_count_ctrl: RTL and testbench
=================================

ENC_COUNT_CTRL -- requirements
Module: enc_count_ctrl

Interface
REQ-001 Parameter: PULSES_PER_STEP, default 4, quadrature pulses per detent step (legal 1..8).
REQ-002 Parameter: WRAP_DEFAULT, default 1, wrap mode after reset (1 = wrap, 0 = saturate).
REQ-003 The block SHALL have exactly one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  system clock, all state updates on rising edge.
REQ-005 reset  input  1  synchronous active-high reset.
REQ-006 cw  input  1  single-cycle clockwise pulse from encoder decoder.
REQ-007 ccw  input  1  single-cycle counter-clockwise pulse from encoder decoder.
REQ-008 en  input  1  counting enable; when 0, pulses are ignored.
REQ-009 load  input  1  single-cycle request to load load_val.
REQ-010 load_val  input  8  BCD value, tens in [7:4], ones in [3:0].
REQ-011 wrap_set  input  1  single-cycle strobe to latch wrap_in as the wrap mode.
REQ-012 wrap_in  input  1  new wrap mode (1 = wrap, 0 = saturate).
REQ-013 bcd_count  output  8  registered BCD count 00..99.
REQ-014 step_up  output  1  one-cycle pulse, count incremented or up-step attempted at saturation.
REQ-015 step_dn  output  1  one-cycle pulse, count decremented or down-step attempted at saturation.
REQ-016 at_limit  output  1  registered, high while bcd_count is 00 or 99.
REQ-017 load_err  output  1  one-cycle pulse, load rejected because load_val was not valid BCD.

Function
REQ-018 FSM states: IDLE (accumulator 0, no direction), ACC_CW, ACC_CCW.
REQ-019 IDLE: accepted cw -> ACC_CW with accumulator 1; accepted ccw -> ACC_CCW with accumulator 1.
REQ-020 ACC_CW: cw increments the accumulator; ccw restarts accumulation in ACC_CCW with accumulator 1.
REQ-021 ACC_CCW: ccw increments the accumulator; cw restarts accumulation in ACC_CW with accumulator 1.
REQ-022 Accepted pulse = (cw XOR ccw) AND en AND NOT load; cw and ccw high together are ignored with no state change.
REQ-023 When an accepted pulse brings the accumulator to PULSES_PER_STEP, the count SHALL step in the current direction, the accumulator SHALL clear, and the FSM SHALL return to IDLE.
REQ-024 Latency: the step takes effect on the clock edge that samples the triggering pulse; new bcd_count, step_up/step_dn and at_limit are all visible in the following cycle.
REQ-025 Increment rule: the ones digit increments; 9 -> 0 with a carry into tens; 99 -> 00 in wrap mode, holds 99 in saturate mode.
REQ-026 Decrement rule: the ones digit decrements; 0 -> 9 with a borrow from tens; 00 -> 99 in wrap mode, holds 00 in saturate mode.
REQ-027 bcd_count SHALL never hold a non-BCD digit (A..F).
REQ-028 step_up/step_dn SHALL pulse on every completed step, including a saturated step that leaves the count unchanged.
REQ-029 load with valid BCD: bcd_count <= load_val, accumulator cleared, FSM -> IDLE, and the same-cycle pulse is discarded.
REQ-030 load with invalid BCD: bcd_count unchanged, FSM and accumulator cleared, load_err pulses for one cycle.
REQ-031 Priority: reset > load > wrap_set > counting; wrap_set in the same cycle as a step applies to the following steps only.
REQ-032 en = 0 holds FSM, accumulator and count; partial accumulation is kept until a pulse resumes it or the direction reverses.

Reset
REQ-033 On reset: bcd_count = 00, FSM = IDLE, accumulator = 0, wrap mode = WRAP_DEFAULT, step_up = step_dn = load_err = 0, at_limit = 1.
REQ-034 Reset asserted mid-accumulation SHALL discard the partial count; the first step after release needs a full PULSES_PER_STEP pulses.

Verification
REQ-035 From reset, 4 cw pulses -> bcd_count 01 and one step_up pulse; 40 cw pulses -> bcd_count 10.
REQ-036 3 cw then 4 ccw from 05 -> bcd_count 04 (the cw partial is discarded); exactly one step_dn.
REQ-037 Load 99, wrap mode, 4 cw -> 00; load 99, saturate mode, 4 cw -> 99 with step_up pulsed and at_limit held at 1.
REQ-038 From 00, wrap mode, 4 ccw -> 99; from 10, 4 ccw -> 09 (borrow).
REQ-039 load_val 8'h3C -> load_err pulses and the count is unchanged; cw and ccw high together for 10 cycles -> no change.
REQ-040 2 cw, then reset for 1 cycle, then 2 cw -> bcd_count 00; 2 more cw -> 01.

Source files
------------

// File: rtl/enc_count_ctrl.sv
// Quadrature detent counter: accumulates encoder pulses per direction and
// steps a two-digit BCD count (wrap or saturate) once a full detent is seen.
//
// state   | meaning
// IDLE    | accumulator empty, no direction latched
// ACC_CW  | accumulating clockwise pulses
// ACC_CCW | accumulating counter-clockwise pulses
module enc_count_ctrl #(
    parameter int   PULSES_PER_STEP = 4,
    parameter logic WRAP_DEFAULT    = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cw,
    input  logic       ccw,
    input  logic       en,
    input  logic       load,
    input  logic [7:0] load_val,
    input  logic       wrap_set,
    input  logic       wrap_in,
    output logic [7:0] bcd_count,
    output logic       step_up,
    output logic       step_dn,
    output logic       at_limit,
    output logic       load_err
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] ACC_CW  = 2'd1;
    localparam logic [1:0] ACC_CCW = 2'd2;
    localparam logic [3:0] PPS     = 4'(PULSES_PER_STEP);

    logic [1:0] state, state_nx;
    logic [3:0] acc, acc_nx, acc_inc;
    logic       wrap_mode, wrap_nx;
    logic [7:0] count_nx;
    logic       up_nx, dn_nx, err_nx;
    logic       pulse_ok, load_valid, same_dir;

    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic wrap);
        logic [7:0] r;
        if (v[3:0] != 4'd9)
            r = {v[7:4], v[3:0] + 4'd1};
        else if (v[7:4] != 4'd9)
            r = {v[7:4] + 4'd1, 4'd0};
        else
            r = wrap ? 8'h00 : 8'h99;
        return r;
    endfunction

    function automatic logic [7:0] bcd_dec(input logic [7:0] v, input logic wrap);
        logic [7:0] r;
        if (v[3:0] != 4'd0)
            r = {v[7:4], v[3:0] - 4'd1};
        else if (v[7:4] != 4'd0)
            r = {v[7:4] - 4'd1, 4'd9};
        else
            r = wrap ? 8'h99 : 8'h00;
        return r;
    endfunction

    assign pulse_ok   = (cw ^ ccw) & en & ~load;
    assign load_valid = (load_val[7:4] <= 4'd9) && (load_val[3:0] <= 4'd9);
    assign same_dir   = (cw && state == ACC_CW) || (ccw && state == ACC_CCW);
    assign acc_inc    = same_dir ? acc + 4'd1 : 4'd1;

    always_comb begin
        state_nx = state;
        acc_nx   = acc;
        count_nx = bcd_count;
        wrap_nx  = wrap_mode;
        up_nx    = 1'b0;
        dn_nx    = 1'b0;
        err_nx   = 1'b0;
        if (load) begin
            state_nx = IDLE;
            acc_nx   = 4'd0;
            if (load_valid)
                count_nx = load_val;
            else
                err_nx = 1'b1;
        end else begin
            // Step below uses the old wrap mode; a new one applies from next cycle.
            if (wrap_set)
                wrap_nx = wrap_in;
            if (pulse_ok) begin
                if (acc_inc == PPS) begin
                    state_nx = IDLE;
                    acc_nx   = 4'd0;
                    if (cw) begin
                        up_nx    = 1'b1;
                        count_nx = bcd_inc(bcd_count, wrap_mode);
                    end else begin
                        dn_nx    = 1'b1;
                        count_nx = bcd_dec(bcd_count, wrap_mode);
                    end
                end else begin
                    acc_nx   = acc_inc;
                    state_nx = cw ? ACC_CW : ACC_CCW;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            acc       <= 4'd0;
            wrap_mode <= WRAP_DEFAULT;
            bcd_count <= 8'h00;
            step_up   <= 1'b0;
            step_dn   <= 1'b0;
            load_err  <= 1'b0;
            at_limit  <= 1'b1;
        end else begin
            state     <= state_nx;
            acc       <= acc_nx;
            wrap_mode <= wrap_nx;
            bcd_count <= count_nx;
            step_up   <= up_nx;
            step_dn   <= dn_nx;
            load_err  <= err_nx;
            at_limit  <= (count_nx == 8'h00) || (count_nx == 8'h99);
        end
    end

endmodule

// File: tb/tb_enc_count_ctrl.sv
// Scoreboarded bench for enc_count_ctrl: expected step/error events are queued
// by the stimulus and consumed by a monitor whenever the DUT pulses an output.
module tb_enc_count_ctrl;

    logic       clk = 1'b0;
    logic       reset, cw, ccw, en, load, wrap_set, wrap_in;
    logic [7:0] load_val;
    logic [7:0] bcd_count;
    logic       step_up, step_dn, at_limit, load_err;

    int total  = 0;
    int passed = 0;

    // event word: {step_up, step_dn, load_err, bcd_count, at_limit}
    logic [11:0] exp_q[$];

    enc_count_ctrl #(.PULSES_PER_STEP(4), .WRAP_DEFAULT(1'b1)) dut (
        .clk(clk), .reset(reset), .cw(cw), .ccw(ccw), .en(en),
        .load(load), .load_val(load_val), .wrap_set(wrap_set), .wrap_in(wrap_in),
        .bcd_count(bcd_count), .step_up(step_up), .step_dn(step_dn),
        .at_limit(at_limit), .load_err(load_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic exp_up(input logic [7:0] c, input logic lim);
        exp_q.push_back({3'b100, c, lim});
    endtask
    task automatic exp_dn(input logic [7:0] c, input logic lim);
        exp_q.push_back({3'b010, c, lim});
    endtask
    task automatic exp_err(input logic [7:0] c, input logic lim);
        exp_q.push_back({3'b001, c, lim});
    endtask

    // Monitor: compares every observed output event against the queue head.
    always @(negedge clk) begin
        if (!reset && (step_up || step_dn || load_err)) begin
            if (exp_q.size() == 0)
                chk("unexpected_event", {20'd0, step_up, step_dn, load_err, bcd_count, at_limit}, 32'd0);
            else
                chk("event", {20'd0, step_up, step_dn, load_err, bcd_count, at_limit},
                    {20'd0, exp_q.pop_front()});
        end
    end

    task automatic pulses(input logic c, input logic cc, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            cw  = c;
            ccw = cc;
        end
        @(negedge clk);
        cw  = 1'b0;
        ccw = 1'b0;
    endtask

    task automatic do_load(input logic [7:0] v);
        @(negedge clk);
        load     = 1'b1;
        load_val = v;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic set_wrap(input logic w);
        @(negedge clk);
        wrap_set = 1'b1;
        wrap_in  = w;
        @(negedge clk);
        wrap_set = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk(name, exp_q.size(), 0);
        exp_q.delete();
    endtask

    logic [7:0] up_tab [10] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05,
                                8'h06, 8'h07, 8'h08, 8'h09, 8'h10};

    initial begin
        reset = 1'b1; cw = 1'b0; ccw = 1'b0; en = 1'b1; load = 1'b0;
        load_val = 8'h00; wrap_set = 1'b0; wrap_in = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset_count", bcd_count, 8'h00);
        chk("reset_limit", at_limit, 1'b1);
        chk("reset_pulses", {step_up, step_dn, load_err}, 3'b000);
        reset = 1'b0;

        for (int i = 0; i < 10; i++) exp_up(up_tab[i], 1'b0);
        pulses(1'b1, 1'b0, 4);
        chk("first_step", bcd_count, 8'h01);
        pulses(1'b1, 1'b0, 36);
        chk("forty_cw", bcd_count, 8'h10);
        drain("drain_cw");

        do_load(8'h05);
        exp_dn(8'h04, 1'b0);
        pulses(1'b1, 1'b0, 3);
        pulses(1'b0, 1'b1, 4);
        chk("reverse_discard", bcd_count, 8'h04);
        drain("drain_rev");

        do_load(8'h99);
        exp_up(8'h00, 1'b1);
        pulses(1'b1, 1'b0, 4);
        chk("wrap_up", bcd_count, 8'h00);
        set_wrap(1'b0);
        do_load(8'h99);
        exp_up(8'h99, 1'b1);
        pulses(1'b1, 1'b0, 4);
        chk("sat_up", bcd_count, 8'h99);
        chk("sat_up_limit", at_limit, 1'b1);
        do_load(8'h00);
        exp_dn(8'h00, 1'b1);
        pulses(1'b0, 1'b1, 4);
        chk("sat_dn", bcd_count, 8'h00);
        set_wrap(1'b1);
        drain("drain_limits");

        do_load(8'h00);
        exp_dn(8'h99, 1'b1);
        pulses(1'b0, 1'b1, 4);
        chk("wrap_dn", bcd_count, 8'h99);
        do_load(8'h10);
        exp_dn(8'h09, 1'b0);
        pulses(1'b0, 1'b1, 4);
        chk("borrow", bcd_count, 8'h09);
        chk("borrow_limit", at_limit, 1'b0);
        drain("drain_dn");

        exp_err(8'h09, 1'b0);
        do_load(8'h3C);
        chk("bad_load_count", bcd_count, 8'h09);
        pulses(1'b1, 1'b1, 10);
        chk("both_high", bcd_count, 8'h09);
        exp_up(8'h10, 1'b0);
        pulses(1'b1, 1'b0, 4);
        drain("drain_err");

        pulses(1'b1, 1'b0, 2);
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        pulses(1'b1, 1'b0, 2);
        chk("reset_mid_acc", bcd_count, 8'h00);
        exp_up(8'h01, 1'b0);
        pulses(1'b1, 1'b0, 2);
        chk("after_reset", bcd_count, 8'h01);
        drain("drain_reset");

        exp_up(8'h02, 1'b0);
        pulses(1'b1, 1'b0, 2);
        @(negedge clk); en = 1'b0;
        pulses(1'b1, 1'b0, 5);
        chk("en_hold", bcd_count, 8'h01);
        en = 1'b1;
        pulses(1'b1, 1'b0, 2);
        chk("en_resume", bcd_count, 8'h02);
        drain("drain_en");

        @(negedge clk); load = 1'b1; load_val = 8'h50; cw = 1'b1;
        @(negedge clk); load = 1'b0; cw = 1'b0;
        pulses(1'b1, 1'b0, 3);
        chk("load_discard", bcd_count, 8'h50);
        exp_up(8'h51, 1'b0);
        pulses(1'b1, 1'b0, 1);
        drain("drain_load_pulse");

        do_load(8'h99);
        pulses(1'b1, 1'b0, 3);
        exp_up(8'h00, 1'b1);
        @(negedge clk); cw = 1'b1; wrap_set = 1'b1; wrap_in = 1'b0;
        @(negedge clk); cw = 1'b0; wrap_set = 1'b0;
        chk("wrap_set_same_cycle", bcd_count, 8'h00);
        do_load(8'h99);
        exp_up(8'h99, 1'b1);
        pulses(1'b1, 1'b0, 4);
        chk("wrap_set_applied", bcd_count, 8'h99);
        drain("drain_final");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
